hazard_flush_ctrl: RTL and testbench



---
 rtl/hazard_flush_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_flush_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hazard_flush_ctrl.sv
// Hazard/flush controller for the 5-stage core: load-use bubbles, taken-branch
// flushes resolved in MEM, data-memory wait freezes, and saturating perf counters.
module hazard_flush_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    ifid_rs1,
  input  logic [4:0]    ifid_rs2,
  input  logic          ifid_uses_rs2,
  input  logic          idex_memread,
  input  logic [4:0]    idex_rd,
  input  logic          branch_taken,
  input  logic          dmem_busy,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          exmem_flush,
  output logic          pipe_hold,
  output logic [1:0]    state,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t        r_state, w_next_state;
  logic          r_pending, w_next_pending;
  logic [2:0]    r_flush_left, w_next_left;
  logic [CW-1:0] r_stall_count, r_flush_count;
  logic          w_lu, w_take, w_flush_inc;

  always_comb begin
    w_lu = idex_memread && (idex_rd != '0) &&
           ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
  end

  always_comb begin
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    pipe_hold      = 1'b0;
    w_next_state   = r_state;
    w_next_pending = r_pending;
    w_next_left    = r_flush_left;
    w_take         = 1'b0;
    w_flush_inc    = 1'b0;

    unique case (r_state)
      S_RUN, S_MEM_WAIT: begin
        if (dmem_busy) begin
          pc_write       = 1'b0;
          ifid_write     = 1'b0;
          pipe_hold      = 1'b1;
          w_next_pending = (r_state == S_MEM_WAIT) ? (r_pending | branch_taken) : branch_taken;
          w_next_state   = S_MEM_WAIT;
        end else if (branch_taken || r_pending) begin
          w_take = 1'b1;
        end else begin
          w_next_state   = S_RUN;
          w_next_pending = 1'b0;
          if (w_lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // A wait during a flush freezes the countdown; a branch seen meanwhile is kept pending.
        if (dmem_busy) begin
          pc_write       = 1'b0;
          ifid_write     = 1'b0;
          pipe_hold      = 1'b1;
          w_next_pending = r_pending | branch_taken;
        end else if (branch_taken || r_pending) begin
          w_take = 1'b1;
        end else begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          w_next_left = r_flush_left - 3'd1;
          if (r_flush_left <= 3'd1) begin
            w_next_state = S_RUN;
          end
        end
      end
      default: w_next_state = S_RUN;
    endcase

    if (w_take) begin
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
      exmem_flush    = 1'b1;
      pc_write       = 1'b1;
      ifid_write     = 1'b1;
      w_next_pending = 1'b0;
      w_flush_inc    = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_next_left  = RELOAD;
        w_next_state = S_FLUSH;
      end else begin
        w_next_left  = '0;
        w_next_state = S_RUN;
      end
    end

    if (reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      pipe_hold   = 1'b0;
      w_flush_inc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_pending     <= 1'b0;
      r_flush_left  <= '0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_state      <= w_next_state;
      r_pending    <= w_next_pending;
      r_flush_left <= w_next_left;
      if (!pc_write && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      if (w_flush_inc && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign state       = r_state;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the controller.
module tb_hazard_flush_ctrl;

  localparam int unsigned FC   = 3;
  localparam int unsigned CW   = 6;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    ifid_rs1, ifid_rs2, idex_rd;
  logic          ifid_uses_rs2, idex_memread, branch_taken, dmem_busy;
  logic          pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold;
  logic [1:0]    state;
  logic [CW-1:0] stall_count, flush_count;

  hazard_flush_ctrl #(.FLUSH_CYCLES(FC), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pipe_hold(pipe_hold),
    .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: extra flush cycles still owed, waiting-on-memory flag, branch seen while frozen.
  int m_rem, m_stall, m_flush;
  bit m_wait, m_pend;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u2, input bit mr, input logic [4:0] rd,
                      input bit bt, input bit busy);
    bit lu, e_pc, e_ifw, e_if, e_id, e_ex, e_hold;
    int e_state;
    @(negedge clk);
    reset = rst; ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_uses_rs2 = u2;
    idex_memread = mr; idex_rd = rd; branch_taken = bt; dmem_busy = busy;
    #1;
    lu = mr && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
    {e_pc, e_ifw, e_if, e_id, e_ex, e_hold} = 6'b110000;
    if (!rst) begin
      if (busy)                  {e_pc, e_ifw, e_hold} = 3'b001;
      else if (bt || m_pend)     {e_if, e_id, e_ex} = 3'b111;
      else if (m_rem > 0)        {e_if, e_id} = 2'b11;
      else if (lu)               {e_pc, e_ifw, e_id} = 3'b001;
    end
    e_state = (m_rem > 0) ? 2 : (m_wait ? 1 : 0);
    check("pc_write", pc_write, e_pc);
    check("ifid_write", ifid_write, e_ifw);
    check("ifid_flush", ifid_flush, e_if);
    check("idex_flush", idex_flush, e_id);
    check("exmem_flush", exmem_flush, e_ex);
    check("pipe_hold", pipe_hold, e_hold);
    check("state", state, e_state);
    check("stall_count", stall_count, m_stall);
    check("flush_count", flush_count, m_flush);
    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_wait = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc && m_stall < CMAX) m_stall++;
      if (busy) begin
        m_pend = m_pend | bt;
        m_wait = 1;
      end else begin
        m_wait = 0;
        if (bt || m_pend) begin
          m_pend = 0;
          m_rem  = FC - 1;
          if (m_flush < CMAX) m_flush++;
        end else if (m_rem > 0) begin
          m_rem--;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0);
  endtask

  initial begin
    int busy_left;
    reset = 1'b1; ifid_rs1 = '0; ifid_rs2 = '0; ifid_uses_rs2 = 1'b0;
    idex_memread = 1'b0; idex_rd = '0; branch_taken = 1'b0; dmem_busy = 1'b0;
    repeat (2) @(posedge clk);
    m_rem = 0; m_wait = 0; m_pend = 0; m_stall = 0; m_flush = 0;

    // Reset state and load-use on rs1
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5'd5, 5'd9, 0, 1, 5'd5, 0, 0);
    step(0, 5'd5, 5'd9, 0, 0, 5'd5, 0, 0);
    #1 check("lu_stall_cnt", stall_count, 1);

    // No false stalls: rs2 not used, and rd=x0
    step(0, 5'd1, 5'd7, 0, 1, 5'd7, 0, 0);
    step(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0);
    #1 check("no_false_stall", stall_count, 1);
    step(0, 5'd1, 5'd7, 1, 1, 5'd7, 0, 0);
    #1 check("rs2_stall", stall_count, 2);

    // Taken branch, FC=3
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 1, 0);
    #1 check("br_state_flush", state, 2);
    idle(3);
    #1 check("br_flush_cnt", flush_count, 1);
    check("br_back_run", state, 0);

    // Busy for 4 cycles with a branch in the 2nd
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 1, 1);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1);
    #1 check("busy_no_flush_yet", flush_count, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0);
    #1 check("busy_stall_cnt", stall_count, 4);
    check("busy_flush_cnt", flush_count, 1);
    idle(3);

    // Branch and load-use together
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5'd4, 5'd2, 0, 1, 5'd4, 1, 0);
    #1 check("br_lu_no_stall", stall_count, 0);

    // Reset mid-flush (flush_left=2)
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 1, 0);
    step(1, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0);
    #1 check("rst_mid_state", state, 0);
    check("rst_mid_fcnt", flush_count, 0);
    check("rst_mid_flush", ifid_flush, 0);

    // Random traffic; small register range makes hazards frequent
    busy_left = 0;
    for (int i = 0; i < 1500; i++) begin
      bit b;
      if (busy_left == 0 && $urandom_range(0, 5) == 0) busy_left = $urandom_range(1, 5);
      b = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      step(($urandom_range(0, 199) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0), b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
